// File: rtl/compare_window_pkg.sv
// Shared types and defaults for the compare_window block.
package compare_window_pkg;

  localparam int unsigned DefaultDataW = 4;
  localparam int unsigned DefaultCntW  = 5;
  // Width of the latched window length and accepted-pair count (holds 1..16).
  localparam int unsigned LenW         = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/compare_window_cmp.sv
// Combinational unsigned magnitude comparator; exactly one output is high.
module compare_window_cmp
  import compare_window_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              greater,
  output logic              lesser,
  output logic              equal
);

  assign greater = (A > B);
  assign lesser  = (A < B);
  assign equal   = (A == B);

endmodule

// File: rtl/compare_window.sv
// Windowed compare-and-count engine: counts A>B, A<B, A==B over a window of win_len pairs.
// Optional max-of-A tracking is enabled by defining COMPARE_WINDOW_MAXTRACK_EN.
module compare_window
  import compare_window_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned CNT_W  = DefaultCntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        win_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              greater,
  output logic              lesser,
  output logic              equal,
  output logic [CNT_W-1:0]  gt_cnt,
  output logic [CNT_W-1:0]  lt_cnt,
  output logic [CNT_W-1:0]  eq_cnt,
  output logic              done,
  output logic [DATA_W-1:0] max_a
);

  state_e            state_q;
  logic [LenW-1:0]   len_q;
  logic [LenW-1:0]   acc_q;
  logic [LenW-1:0]   acc_d;
  logic              greater_q, lesser_q, equal_q;
  logic [CNT_W-1:0]  gt_cnt_q, lt_cnt_q, eq_cnt_q;
  logic              cmp_gt, cmp_lt, cmp_eq;
  logic              start_go;
  logic              accept;

  compare_window_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .A       (A),
    .B       (B),
    .greater (cmp_gt),
    .lesser  (cmp_lt),
    .equal   (cmp_eq)
  );

  always_comb begin
    acc_d    = acc_q + LenW'(1);
    start_go = (state_q != RUN) && start;
    accept   = (state_q == RUN) && in_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      acc_q     <= '0;
      greater_q <= 1'b0;
      lesser_q  <= 1'b0;
      equal_q   <= 1'b0;
      gt_cnt_q  <= '0;
      lt_cnt_q  <= '0;
      eq_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= RUN;
            len_q     <= (win_len == 4'd0) ? LenW'(16) : LenW'(win_len);
            acc_q     <= '0;
            greater_q <= 1'b0;
            lesser_q  <= 1'b0;
            equal_q   <= 1'b0;
            gt_cnt_q  <= '0;
            lt_cnt_q  <= '0;
            eq_cnt_q  <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (in_valid) begin
            greater_q <= cmp_gt;
            lesser_q  <= cmp_lt;
            equal_q   <= cmp_eq;
            gt_cnt_q  <= gt_cnt_q + CNT_W'(cmp_gt);
            lt_cnt_q  <= lt_cnt_q + CNT_W'(cmp_lt);
            eq_cnt_q  <= eq_cnt_q + CNT_W'(cmp_eq);
            acc_q     <= acc_d;
            // Last pair of the window: counts land together with done.
            if (acc_d == len_q) begin
              state_q <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef COMPARE_WINDOW_MAXTRACK_EN
  logic [DATA_W-1:0] max_a_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_a_q <= '0;
    end else if (start_go) begin
      max_a_q <= '0;
    end else if (accept && (A > max_a_q)) begin
      max_a_q <= A;
    end
  end

  assign max_a = max_a_q;
`else
  logic unused_max;
  assign unused_max = start_go ^ accept;
  assign max_a      = '0;
`endif

  assign in_ready = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign greater  = greater_q;
  assign lesser   = lesser_q;
  assign equal    = equal_q;
  assign gt_cnt   = gt_cnt_q;
  assign lt_cnt   = lt_cnt_q;
  assign eq_cnt   = eq_cnt_q;

endmodule

// File: tb/tb_compare_window.sv
// Self-checking bench for compare_window: table-driven pairs with a scoreboard queue.
module tb_compare_window;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] win_len;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a_s, b_s;
  logic       greater, lesser, equal;
  logic [4:0] gt_cnt, lt_cnt, eq_cnt;
  logic       done;
  logic [3:0] max_a;

  compare_window #(
    .DATA_W (4),
    .CNT_W  (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .win_len  (win_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a_s),
    .B        (b_s),
    .greater  (greater),
    .lesser   (lesser),
    .equal    (equal),
    .gt_cnt   (gt_cnt),
    .lt_cnt   (lt_cnt),
    .eq_cnt   (eq_cnt),
    .done     (done),
    .max_a    (max_a)
  );

  always #5 clk = ~clk;

  typedef struct {
    int g, l, e;
    int gc, lc, ec;
    int mx;
    int dn;
  } exp_t;

  typedef struct {
    logic [3:0] a, b;
    int g, l, e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];

  int n_cmp = 0;
  int n_bad = 0;
  int m_g, m_l, m_e, m_gc, m_lc, m_ec, m_mx, m_acc, m_len;
  int done_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_seen++;
  endtask

  task automatic clear_model();
    m_g = 0; m_l = 0; m_e = 0;
    m_gc = 0; m_lc = 0; m_ec = 0;
    m_mx = 0; m_acc = 0;
  endtask

  // Compare every held output against the model (idle/stall cycles).
  task automatic chk_hold(input string tag, input int rdy);
    chk({tag, ".ready"}, 32'(in_ready), rdy);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".flags"}, {29'd0, greater, lesser, equal}, 32'(m_g * 4 + m_l * 2 + m_e));
    chk({tag, ".gt"}, 32'(gt_cnt), m_gc);
    chk({tag, ".lt"}, 32'(lt_cnt), m_lc);
    chk({tag, ".eq"}, 32'(eq_cnt), m_ec);
    chk({tag, ".max"}, 32'(max_a), m_mx);
  endtask

  task automatic do_start(input int len);
    start   = 1'b1;
    win_len = len[3:0];
    cycle();
    start = 1'b0;
    clear_model();
    m_len = (len == 0) ? 16 : len;
    chk_hold("start", 1);
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input int g, input int l,
                      input int e);
    exp_t x;
    a_s = a;
    b_s = b;
    in_valid = 1'b1;
    m_acc++;
    m_g = g; m_l = l; m_e = e;
    m_gc += g; m_lc += l; m_ec += e;
`ifdef COMPARE_WINDOW_MAXTRACK_EN
    if (int'(a) > m_mx) m_mx = int'(a);
`endif
    x.g = m_g; x.l = m_l; x.e = m_e;
    x.gc = m_gc; x.lc = m_lc; x.ec = m_ec;
    x.mx = m_mx;
    x.dn = (m_acc == m_len) ? 1 : 0;
    sb.push_back(x);
    cycle();
    in_valid = 1'b0;
    x = sb.pop_front();
    chk("pair.flags", {29'd0, greater, lesser, equal}, 32'(x.g * 4 + x.l * 2 + x.e));
    chk("pair.gt", 32'(gt_cnt), x.gc);
    chk("pair.lt", 32'(lt_cnt), x.lc);
    chk("pair.eq", 32'(eq_cnt), x.ec);
    chk("pair.max", 32'(max_a), x.mx);
    chk("pair.done", 32'(done), x.dn);
    chk("pair.ready", 32'(in_ready), 1 - x.dn);
  endtask

  task automatic send_tbl(input int i);
    send(tbl[i].a, tbl[i].b, tbl[i].g, tbl[i].l, tbl[i].e);
  endtask

  initial begin
    tbl[0] = '{a: 4'd5,  b: 4'd9,  g: 0, l: 1, e: 0};
    tbl[1] = '{a: 4'd11, b: 4'd11, g: 0, l: 0, e: 1};
    tbl[2] = '{a: 4'd9,  b: 4'd6,  g: 1, l: 0, e: 0};
    tbl[3] = '{a: 4'd0,  b: 4'd15, g: 0, l: 1, e: 0};
    tbl[4] = '{a: 4'd15, b: 4'd0,  g: 1, l: 0, e: 0};
    tbl[5] = '{a: 4'd7,  b: 4'd7,  g: 0, l: 0, e: 1};
    tbl[6] = '{a: 4'd8,  b: 4'd7,  g: 1, l: 0, e: 0};
    tbl[7] = '{a: 4'd3,  b: 4'd12, g: 0, l: 1, e: 0};

    rst = 1'b1; start = 1'b0; win_len = 4'd0; in_valid = 1'b0; a_s = '0; b_s = '0;
    done_seen = 0;
    clear_model();
    m_len = 16;
    cycle();
    cycle();
    chk_hold("reset", 0);
    rst = 1'b0;
    cycle();
    chk_hold("post_reset", 0);

    // Basic window of 3, back to back.
    do_start(3);
    for (int i = 0; i < 3; i++) send_tbl(i);
    chk("basic.lt", 32'(lt_cnt), 1);
    chk("basic.eq", 32'(eq_cnt), 1);
    chk("basic.gt", 32'(gt_cnt), 1);
    chk("basic.greater", 32'(greater), 1);
    chk("basic.done", 32'(done), 1);
    cycle();
    chk_hold("basic.after", 0);

    // Pairs offered in IDLE are not consumed.
    in_valid = 1'b1; a_s = 4'd1; b_s = 4'd2;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk_hold("idle_offer", 0);
    end
    in_valid = 1'b0;

    // Window of 5 with stall gaps; a start during RUN must be ignored.
    do_start(5);
    for (int i = 3; i < 8; i++) begin
      send_tbl(i);
      if (i < 7) begin
        a_s = 4'd15; b_s = 4'd0;
        start = (i == 4);
        win_len = 4'd1;
        for (int k = 0; k <= (i % 2); k++) begin
          cycle();
          chk_hold("stall", 1);
        end
        start = 1'b0;
      end
    end
    chk("stall.total", 32'(gt_cnt + lt_cnt + eq_cnt), 5);
    cycle();
    chk_hold("stall.after", 0);

    // 16-pair window, no counter wrap, exactly one done.
    done_seen = 0;
    do_start(0);
    for (int i = 0; i < 16; i++) send(4'd15, 4'd15, 0, 0, 1);
    chk("w16.eq", 32'(eq_cnt), 16);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk_hold("w16.after", 0);
    end
    chk("w16.done_count", 32'(done_seen), 1);

    // Restart from DONE.
    do_start(2);
    send_tbl(0);
    send_tbl(2);
    do_start(1);
    chk("restart.done", 32'(done), 0);
    send_tbl(5);
    cycle();
    chk_hold("restart.after", 0);

    // Mid-window asynchronous reset.
    done_seen = 0;
    do_start(4);
    send_tbl(4);
    send_tbl(6);
    #2 rst = 1'b1;
    #1;
    clear_model();
    chk_hold("midrst", 0);
    cycle();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk_hold("midrst.after", 0);
    end
    chk("midrst.no_done", 32'(done_seen), 0);

    // Max-of-A tracking: A = 4, 14, 3.
    do_start(3);
    send(4'd4, 4'd9, 0, 1, 0);
    send(4'd14, 4'd2, 1, 0, 0);
    send(4'd3, 4'd3, 0, 0, 1);
`ifdef COMPARE_WINDOW_MAXTRACK_EN
    chk("max.final", 32'(max_a), 14);
`else
    chk("max.final", 32'(max_a), 0);
`endif
    cycle();
    chk_hold("max.hold", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
